// File: rtl/xalu_seq16_if.sv
// Nibble bus between the xalu_seq16 sequencer and the 4-bit ALU slice.
//   master : sequencer side. Drives the operand nibbles, function code,
//            carry inputs and complement mode. Receives the slice data,
//            carry outputs and per-nibble status.
//   slave  : slice side, with the opposite directions.
interface xalu_seq16_if;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_f;
    logic       alu_ci_left;
    logic       alu_ci_right;
    logic       alu_com;
    logic [3:0] alu_d;
    logic       alu_co_left;
    logic       alu_co_right;
    logic       alu_zero;
    logic       alu_neg_zero;
    logic       alu_equ;

    modport master (
        output alu_a, alu_b, alu_f, alu_ci_left, alu_ci_right, alu_com,
        input  alu_d, alu_co_left, alu_co_right, alu_zero, alu_neg_zero, alu_equ
    );

    modport slave (
        input  alu_a, alu_b, alu_f, alu_ci_left, alu_ci_right, alu_com,
        output alu_d, alu_co_left, alu_co_right, alu_zero, alu_neg_zero, alu_equ
    );
endinterface

// File: rtl/xalu_seq16.sv
// xalu_seq16 - multi-cycle sequencer for a combinational 4-bit ALU slice.
// It runs a WIDTH-bit operation (WIDTH = 4*NIB) as NIB slice passes, one
// nibble per clock. The carry chain is closed through a register between
// passes. The nibble results are collected in a shadow register and the
// status flags are AND-accumulated.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request, sampled only in IDLE
//   op, com, cin      function code, complement mode, carry/fill in
//   a, b              WIDTH-bit operands
//   busy, done        busy during RUN, one-cycle done pulse on completion
//   result, cout      result register and carry/shift-out
//   zero, neg_zero,   aggregate slice status flags
//   equ
//   alu               nibble bus to the slice (master side)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; slice bus held at 0; results held
// S_RUN  | one nibble per cycle, NIB cycles; cnt_q counts down to 0
module xalu_seq16 #(
    parameter  int NIB   = 4,
    localparam int WIDTH = 4 * NIB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             com,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg_zero,
    output logic             equ,
    xalu_seq16_if.master     alu
);
    localparam int CW = $clog2(NIB);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             com_q, com_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             zacc_q, zacc_d, nzacc_q, nzacc_d, eacc_q, eacc_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d, zero_q, zero_d, nz_q, nz_d, equ_q, equ_d;
    logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]       alu_f_q, alu_f_d;
    logic             alu_cil_q, alu_cil_d, alu_cir_q, alu_cir_d;
    logic             alu_com_q, alu_com_d;

    logic             is_shr_q;
    logic             is_shr_in;
    logic [CW-1:0]    j_cur, j_nxt, j_first;
    logic             carry_new;

    function automatic logic [3:0] nib_of(input logic [WIDTH-1:0] x,
                                          input logic [CW-1:0]    j);
        logic [WIDTH-1:0] t;
        t = x >> {j, 2'b00};
        return t[3:0];
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        com_d     = com_q;
        acc_d     = acc_q;
        zacc_d    = zacc_q;
        nzacc_d   = nzacc_q;
        eacc_d    = eacc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        cout_d    = cout_q;
        zero_d    = zero_q;
        nz_d      = nz_q;
        equ_d     = equ_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_f_d   = alu_f_q;
        alu_cil_d = alu_cil_q;
        alu_cir_d = alu_cir_q;
        alu_com_d = alu_com_q;

        // SHR walks nibbles MSB first, everything else LSB first. The carry
        // register lives in the registered ci_left/ci_right drive.
        is_shr_q  = (op_q == OP_SHR);
        is_shr_in = (op == OP_SHR);
        j_cur     = is_shr_q ? cnt_q : CW'(NIB - 1) - cnt_q;
        j_nxt     = is_shr_q ? j_cur - CW'(1) : j_cur + CW'(1);
        j_first   = is_shr_in ? CW'(NIB - 1) : CW'(0);
        carry_new = is_shr_q ? alu.alu_co_right : alu.alu_co_left;

        case (state_q)
            S_IDLE: begin
                alu_a_d   = '0;
                alu_b_d   = '0;
                alu_f_d   = '0;
                alu_cil_d = 1'b0;
                alu_cir_d = 1'b0;
                alu_com_d = 1'b0;
                if (start) begin
                    state_d   = S_RUN;
                    busy_d    = 1'b1;
                    cnt_d     = CW'(NIB - 1);
                    a_d       = a;
                    b_d       = b;
                    op_d      = op;
                    com_d     = com;
                    zacc_d    = 1'b1;
                    nzacc_d   = 1'b1;
                    eacc_d    = 1'b1;
                    alu_a_d   = nib_of(a, j_first);
                    alu_b_d   = nib_of(b, j_first);
                    alu_f_d   = op;
                    alu_com_d = com;
                    alu_cil_d = is_shr_in & cin;
                    alu_cir_d = ~is_shr_in & cin;
                end
            end
            S_RUN: begin
                acc_d[{j_cur, 2'b00} +: 4] = alu.alu_d;
                zacc_d  = zacc_q & alu.alu_zero;
                nzacc_d = nzacc_q & alu.alu_neg_zero;
                eacc_d  = eacc_q & alu.alu_equ;
                if (cnt_q == '0) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    result_d  = acc_d;
                    cout_d    = ((op_q == OP_ADD) || (op_q == OP_SHR) ||
                                 (op_q == OP_SHL)) & carry_new;
                    zero_d    = zacc_d;
                    nz_d      = nzacc_d;
                    equ_d     = eacc_d;
                    alu_a_d   = '0;
                    alu_b_d   = '0;
                    alu_f_d   = '0;
                    alu_cil_d = 1'b0;
                    alu_cir_d = 1'b0;
                    alu_com_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q - CW'(1);
                    alu_a_d   = nib_of(a_q, j_nxt);
                    alu_b_d   = nib_of(b_q, j_nxt);
                    alu_cil_d = is_shr_q & carry_new;
                    alu_cir_d = ~is_shr_q & carry_new;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            com_q     <= 1'b0;
            acc_q     <= '0;
            zacc_q    <= 1'b0;
            nzacc_q   <= 1'b0;
            eacc_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            zero_q    <= 1'b0;
            nz_q      <= 1'b0;
            equ_q     <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_f_q   <= '0;
            alu_cil_q <= 1'b0;
            alu_cir_q <= 1'b0;
            alu_com_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            com_q     <= com_d;
            acc_q     <= acc_d;
            zacc_q    <= zacc_d;
            nzacc_q   <= nzacc_d;
            eacc_q    <= eacc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            zero_q    <= zero_d;
            nz_q      <= nz_d;
            equ_q     <= equ_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_f_q   <= alu_f_d;
            alu_cil_q <= alu_cil_d;
            alu_cir_q <= alu_cir_d;
            alu_com_q <= alu_com_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign zero     = zero_q;
    assign neg_zero = nz_q;
    assign equ      = equ_q;

    assign alu.alu_a        = alu_a_q;
    assign alu.alu_b        = alu_b_q;
    assign alu.alu_f        = alu_f_q;
    assign alu.alu_ci_left  = alu_cil_q;
    assign alu.alu_ci_right = alu_cir_q;
    assign alu.alu_com      = alu_com_q;
endmodule

// File: tb/tb_xalu_seq16.sv
module tb_xalu_seq16;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic         com;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         neg_zero;
    logic         equ;

    int n_tests = 0;
    int n_fail  = 0;

    xalu_seq16_if bus ();

    xalu_seq16 #(.NIB(NIB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .com      (com),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .zero     (zero),
        .neg_zero (neg_zero),
        .equ      (equ),
        .alu      (bus)
    );

    always #5 clk = ~clk;

    // Combinational 4-bit slice the sequencer drives.
    logic [4:0] sl_s;
    logic [3:0] sl_d;
    logic       sl_col;
    logic       sl_cor;
    always_comb begin
        sl_s   = '0;
        sl_d   = '0;
        sl_col = 1'b0;
        sl_cor = 1'b0;
        case (bus.alu_f)
            3'd0: begin
                sl_s   = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + 5'(bus.alu_ci_right);
                sl_d   = sl_s[3:0];
                sl_col = sl_s[4];
            end
            3'd1: sl_d = bus.alu_a & bus.alu_b;
            3'd2: sl_d = bus.alu_a | bus.alu_b;
            3'd3: sl_d = bus.alu_a ^ bus.alu_b;
            3'd4: sl_d = bus.alu_a;
            3'd5: sl_d = bus.alu_b;
            3'd6: begin
                sl_d   = {bus.alu_ci_left, bus.alu_a[3:1]};
                sl_cor = bus.alu_a[0];
            end
            default: begin
                sl_d   = {bus.alu_a[2:0], bus.alu_ci_right};
                sl_col = bus.alu_a[3];
            end
        endcase
        if (bus.alu_com) sl_d = ~sl_d;
        bus.alu_d        = sl_d;
        bus.alu_co_left  = sl_col;
        bus.alu_co_right = sl_cor;
        bus.alu_zero     = (sl_d == 4'h0);
        bus.alu_neg_zero = (sl_d == 4'hF);
        bus.alu_equ      = (bus.alu_a == bus.alu_b);
    end

    // Whole-word reference: what the complete operation should produce.
    function automatic void ref_model(input logic [2:0] o, input logic cm, input logic ci,
                                      input logic [W-1:0] av, input logic [W-1:0] bv,
                                      output logic [W-1:0] r, output logic co,
                                      output logic z, output logic nz, output logic eq);
        logic [W:0] s;
        co = 1'b0;
        r  = '0;
        case (o)
            3'd0: begin
                s  = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
                r  = s[W-1:0];
                co = s[W];
            end
            3'd1: r = av & bv;
            3'd2: r = av | bv;
            3'd3: r = av ^ bv;
            3'd4: r = av;
            3'd5: r = bv;
            3'd6: begin r = {ci, av[W-1:1]}; co = av[0]; end
            default: begin r = {av[W-2:0], ci}; co = av[W-1]; end
        endcase
        if (cm) r = ~r;
        z  = (r == '0);
        nz = (r == '1);
        eq = (av == bv);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] bus_word();
        return {bus.alu_a, bus.alu_b, bus.alu_f, bus.alu_ci_left, bus.alu_ci_right, bus.alu_com};
    endfunction

    // Issue one operation from IDLE, scramble the inputs after accept,
    // and check latency, busy length, nibble order on alu_a and outputs.
    task automatic run_op(input string tag, input logic [2:0] o, input logic cm,
                          input logic ci, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] er;
        logic [W-1:0] sh;
        logic         eco, ez, enz, eeq;
        logic [3:0]   seen_a [NIB];
        int           lat, nbusy, j;
        ref_model(o, cm, ci, av, bv, er, eco, ez, enz, eeq);
        for (int k = 0; k < NIB; k++) seen_a[k] = 4'h0;
        op = o; com = cm; cin = ci; a = av; b = bv; start = 1'b1;
        lat = 0;
        nbusy = 0;
        for (int t = 1; t <= 20; t++) begin
            step();
            if (t == 1) begin
                start = 1'b0;
                op  = 3'($urandom);
                com = 1'($urandom);
                cin = 1'($urandom);
                a   = W'($urandom);
                b   = W'($urandom);
            end
            if (busy) begin
                if (nbusy < NIB) seen_a[nbusy] = bus.alu_a;
                nbusy++;
            end
            if (done) begin
                lat = t;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(NIB + 1));
        chk({tag, "_busy_len"}, 64'(nbusy), 64'(NIB));
        chk({tag, "_result"}, 64'(result), 64'(er));
        chk({tag, "_cout"}, 64'(cout), 64'(eco));
        chk({tag, "_flags"}, 64'({zero, neg_zero, equ}), 64'({ez, enz, eeq}));
        chk({tag, "_idle_bus"}, 64'(bus_word()), 64'(0));
        for (int k = 0; k < NIB; k++) begin
            j  = (o == 3'd6) ? NIB - 1 - k : k;
            sh = av >> (4 * j);
            chk($sformatf("%s_alu_a_k%0d", tag, k), 64'(seen_a[k]), 64'(sh[3:0]));
        end
    endtask

    logic [2:0]   h_op [3];
    logic         h_com [3];
    logic         h_cin [3];
    logic [W-1:0] h_a [3];
    logic [W-1:0] h_b [3];
    logic [W-1:0] er;
    logic         eco, ez, enz, eeq;
    int           ndone;
    int           vi;

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; com = 1'b0; cin = 1'b0; a = '0; b = '0;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_flags", 64'({cout, zero, neg_zero, equ}), 64'(0));
        chk("rst_bus", 64'(bus_word()), 64'(0));
        rst = 1'b0;
        step();
        chk("idle_busy", 64'(busy), 64'(0));

        // Directed vectors from the plan, with literal cross-checks.
        run_op("add1", 3'd0, 1'b0, 1'b0, 16'h1234, 16'h0FCC);
        chk("add1_lit", 64'({result, cout, zero, equ}), 64'({16'h2200, 3'b000}));
        run_op("add2", 3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        chk("add2_lit", 64'({result, cout, zero, neg_zero}), 64'({16'h0000, 3'b110}));
        run_op("add2c", 3'd0, 1'b1, 1'b0, 16'hFFFF, 16'h0001);
        chk("add2c_lit", 64'({result, cout, zero, neg_zero}), 64'({16'hFFFF, 3'b101}));
        run_op("shl", 3'd7, 1'b0, 1'b1, 16'h8001, 16'h0000);
        chk("shl_lit", 64'({result, cout}), 64'({16'h0003, 1'b1}));
        run_op("shr", 3'd6, 1'b0, 1'b0, 16'h8001, 16'h0000);
        chk("shr_lit", 64'({result, cout}), 64'({16'h4000, 1'b1}));
        run_op("xor", 3'd3, 1'b0, 1'b0, 16'h5A5A, 16'h5A5A);
        chk("xor_lit", 64'({result, zero, equ}), 64'({16'h0000, 2'b11}));
        run_op("passb", 3'd5, 1'b0, 1'b1, 16'h5A5A, 16'h5A5B);
        chk("passb_lit", 64'({result, equ, cout}), 64'({16'h5A5B, 2'b00}));

        // Back-to-back with start held high; inputs during RUN are noise.
        for (int i = 0; i < 3; i++) begin
            h_op[i] = 3'($urandom); h_com[i] = 1'($urandom); h_cin[i] = 1'($urandom);
            h_a[i]  = W'($urandom); h_b[i]  = W'($urandom);
        end
        op = h_op[0]; com = h_com[0]; cin = h_cin[0]; a = h_a[0]; b = h_b[0];
        start = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            step();
            chk($sformatf("b2b_busy_t%0d", t), 64'(busy), 64'((t % 5) != 0));
            chk($sformatf("b2b_done_t%0d", t), 64'(done), 64'((t % 5) == 0));
            if ((t % 5) == 0) begin
                vi = t / 5 - 1;
                ref_model(h_op[vi], h_com[vi], h_cin[vi], h_a[vi], h_b[vi], er, eco, ez, enz, eeq);
                chk($sformatf("b2b_result%0d", vi), 64'(result), 64'(er));
                chk($sformatf("b2b_status%0d", vi), 64'({cout, zero, neg_zero, equ}),
                    64'({eco, ez, enz, eeq}));
                if (t < 15) begin
                    op = h_op[vi+1]; com = h_com[vi+1]; cin = h_cin[vi+1];
                    a = h_a[vi+1]; b = h_b[vi+1];
                end else begin
                    start = 1'b0;
                end
            end else if ((t % 5) == 1) begin
                op = 3'($urandom); com = 1'($urandom); cin = 1'($urandom);
                a = W'($urandom); b = W'($urandom);
            end
        end
        step();
        chk("b2b_stop_busy", 64'(busy), 64'(0));

        // Reset in the middle of an ADD.
        op = 3'd0; com = 1'b0; cin = 1'b1; a = 16'h7777; b = 16'h1111; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("mid_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy_done", 64'({busy, done}), 64'(0));
        chk("mrst_result", 64'(result), 64'(0));
        chk("mrst_flags", 64'({cout, zero, neg_zero, equ}), 64'(0));
        chk("mrst_bus", 64'(bus_word()), 64'(0));
        ndone = 0;
        for (int t = 0; t < 8; t++) begin
            step();
            if (done || busy) ndone++;
        end
        chk("mrst_no_done", 64'(ndone), 64'(0));
        run_op("post_rst", 3'd0, 1'b0, 1'b1, 16'h7777, 16'h1111);

        // Randomised operations.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            run_op($sformatf("rnd%0d", i), 3'($urandom), 1'($urandom), 1'($urandom), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
